// File: rtl/n1_sbus_ram.sv
// N1 stack bus responder: pipelined Wishbone slave over a shared PS/RS stack RAM.
// Optional build macro SBUS_RAM_STALL_EN adds LFSR-driven stall injection.
module n1_sbus_ram #(
  parameter int unsigned SP_WIDTH   = 12,
  parameter int unsigned CELL_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  input  logic                  sbus_cyc_i,
  input  logic                  sbus_stb_i,
  input  logic                  sbus_we_i,
  input  logic [SP_WIDTH-1:0]   sbus_adr_i,
  input  logic                  sbus_tga_ps_i,
  input  logic                  sbus_tga_rs_i,
  input  logic [CELL_WIDTH-1:0] sbus_dat_i,
  output logic                  sbus_ack_o,
  output logic                  sbus_err_o,
  output logic                  sbus_stall_o,
  output logic [CELL_WIDTH-1:0] sbus_dat_o
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RESP = 1'b1;
  localparam int unsigned DEPTH = 1 << SP_WIDTH;

  logic [0:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic [CELL_WIDTH-1:0] dat_q;
  logic [CELL_WIDTH-1:0] mem [DEPTH];

  logic stall;
  logic accept;
  logic tag_ok;
  logic wr_en;
  logic rd_en;

`ifdef SBUS_RAM_STALL_EN
  logic [3:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      lfsr_q <= 4'b0001;
    end else begin
      lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
  end

  assign stall = lfsr_q[3];
`else
  assign stall = 1'b0;
`endif

  assign accept = sbus_cyc_i & sbus_stb_i & ~stall;
  // Exactly one stack tag must be set; PS/RS separation itself lives in the SAGU.
  assign tag_ok = sbus_tga_ps_i ^ sbus_tga_rs_i;
  assign wr_en  = accept & tag_ok & sbus_we_i;
  assign rd_en  = accept & tag_ok & ~sbus_we_i;

  always_comb begin
    state_d = state_q;
    err_d   = accept & ~tag_ok;
    unique case (state_q)
      STATE_IDLE: if (accept) state_d = STATE_RESP;
      STATE_RESP: state_d = accept ? STATE_RESP : STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      state_q <= STATE_IDLE;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (rd_en) dat_q <= mem[sbus_adr_i];
    end
  end

  // Storage is deliberately outside reset so stacks survive a core reset.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i && wr_en) mem[sbus_adr_i] <= sbus_dat_i;
  end

  assign sbus_ack_o   = (state_q == STATE_RESP) & ~err_q;
  assign sbus_err_o   = (state_q == STATE_RESP) & err_q;
  assign sbus_stall_o = stall;
  assign sbus_dat_o   = dat_q;

endmodule

// File: tb/tb_n1_sbus_ram.sv
// Directed self-checking bench for n1_sbus_ram (default build, stall injection off).
module tb_n1_sbus_ram;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we, ps, rs;
  logic [11:0] adr;
  logic [15:0] wdat;
  logic        ack, err, stall;
  logic [15:0] rdat;

  int checks = 0;
  int errors = 0;

  n1_sbus_ram #(.SP_WIDTH(12), .CELL_WIDTH(16)) dut (
    .clk_i        (clk),
    .sync_rst_i   (rst_n),
    .sbus_cyc_i   (cyc),
    .sbus_stb_i   (stb),
    .sbus_we_i    (we),
    .sbus_adr_i   (adr),
    .sbus_tga_ps_i(ps),
    .sbus_tga_rs_i(rs),
    .sbus_dat_i   (wdat),
    .sbus_ack_o   (ack),
    .sbus_err_o   (err),
    .sbus_stall_o (stall),
    .sbus_dat_o   (rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample #1 after the edge; inputs change at the same point for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [11:0] a, input logic p, input logic r,
                     input logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; ps = p; rs = r; wdat = d;
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ps = 1'b0; rs = 1'b0;
  endtask

  task automatic resp(input string tag, input logic a, input logic e);
    chk({tag, "_ack"}, {31'd0, ack}, {31'd0, a});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
  endtask

  initial begin
    rst_n = 1'b0; adr = '0; wdat = '0;
    idle();

    // Reset and idle
    for (int i = 0; i < 2; i++) begin
      tick();
      resp("rst", 1'b0, 1'b0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_dat", {16'd0, rdat}, 32'h0000);
    end
    rst_n = 1'b1;
    tick();
    resp("idle", 1'b0, 1'b0);
    chk("idle_dat", {16'd0, rdat}, 32'h0000);

    // Write then immediate read of the same cell
    req(1'b1, 12'h010, 1'b1, 1'b0, 16'hA5C3);
    tick();
    resp("wr1", 1'b1, 1'b0);
    chk("wr1_dat_hold", {16'd0, rdat}, 32'h0000);
    req(1'b0, 12'h010, 1'b1, 1'b0, 16'h0000);
    tick();
    resp("rd1", 1'b1, 1'b0);
    chk("rd1_dat", {16'd0, rdat}, 32'hA5C3);
    idle();
    tick();
    resp("rd1_done", 1'b0, 1'b0);

    // Pipelined burst at the top of the address range
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 12'hFFC + 12'(i), 1'b0, 1'b1, 16'(i + 1));
      tick();
      resp("bwr", 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 12'hFFC + 12'(i), 1'b0, 1'b1, 16'h0000);
      tick();
      resp("brd", 1'b1, 1'b0);
      chk("brd_dat", {16'd0, rdat}, 32'(i + 1));
    end
    idle();
    tick();
    resp("burst_done", 1'b0, 1'b0);
    chk("burst_dat_hold", {16'd0, rdat}, 32'h0004);

    // Illegal tags: both set on a read, neither set on a write
    req(1'b1, 12'h020, 1'b1, 1'b0, 16'h1234);
    tick();
    resp("wr20", 1'b1, 1'b0);
    req(1'b0, 12'h020, 1'b1, 1'b1, 16'h0000);
    tick();
    resp("bad_rd", 1'b0, 1'b1);
    chk("bad_rd_dat", {16'd0, rdat}, 32'h0004);
    req(1'b1, 12'h020, 1'b0, 1'b0, 16'hBEEF);
    tick();
    resp("bad_wr", 1'b0, 1'b1);
    req(1'b0, 12'h020, 1'b1, 1'b0, 16'h0000);
    tick();
    resp("rd20", 1'b1, 1'b0);
    chk("rd20_dat", {16'd0, rdat}, 32'h1234);

    // Abort: cyc dropped (stb still high) right after an accepted write
    req(1'b1, 12'h030, 1'b0, 1'b1, 16'h5A5A);
    tick();
    resp("ab_wr", 1'b1, 1'b0);
    cyc = 1'b0;
    tick();
    resp("ab_drop", 1'b0, 1'b0);
    // stb low with cyc high must not be accepted either
    cyc = 1'b1; stb = 1'b0;
    tick();
    resp("no_stb", 1'b0, 1'b0);
    req(1'b0, 12'h030, 1'b0, 1'b1, 16'h0000);
    tick();
    resp("ab_rd", 1'b1, 1'b0);
    chk("ab_rd_dat", {16'd0, rdat}, 32'h5A5A);
    chk("stall_off", {31'd0, stall}, 32'd0);

    // RAM contents survive reset while outputs clear
    idle();
    rst_n = 1'b0;
    tick();
    resp("rst2", 1'b0, 1'b0);
    chk("rst2_dat", {16'd0, rdat}, 32'h0000);
    rst_n = 1'b1;
    req(1'b0, 12'h010, 1'b1, 1'b0, 16'h0000);
    tick();
    resp("keep_rd", 1'b1, 1'b0);
    chk("keep_dat", {16'd0, rdat}, 32'hA5C3);
    idle();
    tick();
    resp("end", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
